// File: rtl/qa_drv_hc_pkg.sv
// Shared types and message-field positions for the host-channel client exerciser.
// A message's low 32 bits are {count[30:0], last}; the CHECK report packs {err[15:0], msg[15:0]}.
package qa_drv_hc_pkg;

    typedef enum logic [1:0] {
        MODE_NOP      = 2'd0,
        MODE_CHECK    = 2'd1,
        MODE_GENERATE = 2'd2,
        MODE_ECHO     = 2'd3
    } t_qa_hc_exer_mode;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_REPORT   = 3'd2,
        ST_GENERATE = 3'd3,
        ST_ECHO     = 3'd4
    } t_qa_hc_exer_state;

    localparam int MSG_LAST_BIT  = 0;
    localparam int MSG_COUNT_LSB = 1;
    localparam int MSG_COUNT_MSB = 31;

    localparam int RPT_MSG_LSB = 0;
    localparam int RPT_MSG_MSB = 15;
    localparam int RPT_ERR_LSB = 16;
    localparam int RPT_ERR_MSB = 31;

    function automatic logic [31:0] qa_hc_msg(input logic [30:0] count, input logic last);
        return {count, last};
    endfunction

endpackage

// File: rtl/qa_drv_hc_seq_checker.sv
// Sequence checker for a counted down-stream: tracks the expected next count and flags
// per-message errors (sequence break and/or wrong last flag, counted once).
module qa_drv_hc_seq_checker
    import qa_drv_hc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_msg_valid,
    input  logic [31:0] i_data,
    output logic        o_err_inc
);

    logic [30:0] r_exp;
    logic        r_first;

    logic [30:0] w_count;
    logic        w_last;
    logic        w_seq_err;
    logic        w_last_err;

    assign w_count = i_data[MSG_COUNT_MSB:MSG_COUNT_LSB];
    assign w_last  = i_data[MSG_LAST_BIT];

    // The first message of a stream only seeds the expectation.
    assign w_seq_err  = !r_first && (w_count != r_exp);
    assign w_last_err = w_last != (w_count == 31'd1);
    assign o_err_inc  = i_msg_valid && (w_seq_err || w_last_err);

    always_ff @(posedge clk) begin
        if (reset || i_start) begin
            r_first <= 1'b1;
            r_exp   <= '0;
        end else if (i_msg_valid) begin
            // Always follow the received count so a single gap costs one error.
            r_first <= 1'b0;
            r_exp   <= w_count - 31'd1;
        end
    end

endmodule

// File: rtl/qa_drv_hc_client_exerciser.sv
// Client-side endpoint of the host-channel test path: checks, generates or echoes
// counted message streams through the to-client/from-client FIFOs.
module qa_drv_hc_client_exerciser
    import qa_drv_hc_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic [1:0]            cfg_mode,
    input  logic [30:0]           cfg_count,
    input  logic [DATA_WIDTH-1:0] rx_fifo_data,
    input  logic                  rx_fifo_rdy,
    output logic                  rx_fifo_enable,
    output logic [DATA_WIDTH-1:0] tx_fifo_data,
    input  logic                  tx_fifo_rdy,
    output logic                  tx_fifo_enable,
    output logic                  busy,
    output logic                  done,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [31:0]           msg_count,
    output logic [2:0]            dbg_state
);

    // Handshake: a FIFO transfer happens in a cycle where enable is high; enable is
    // only ever raised while the matching rdy is high, so enable alone marks a transfer.

    t_qa_hc_exer_state r_state;
    t_qa_hc_exer_state w_next_state;

    logic [30:0]          r_cnt;
    logic [ERR_WIDTH-1:0] r_err_count;
    logic [31:0]          r_msg_count;
    logic                 r_done;

    logic [31:0] w_rx_word;
    logic [31:0] w_tx_word;
    logic [15:0] w_err_rpt;
    logic        w_unused_rx_hi;
    logic        w_start;
    logic        w_msg_inc;
    logic        w_chk_valid;
    logic        w_err_inc;
    logic        w_gen_push;

    assign w_rx_word      = rx_fifo_data[31:0];
    assign w_unused_rx_hi = ^rx_fifo_data[DATA_WIDTH-1:32];
    assign w_err_rpt      = 16'(r_err_count);

    assign w_start     = (r_state == ST_IDLE) && (w_next_state != ST_IDLE);
    assign w_chk_valid = (r_state == ST_CHECK) && rx_fifo_enable;
    assign w_gen_push  = (r_state == ST_GENERATE) && tx_fifo_enable;

    always_comb begin
        w_next_state   = r_state;
        rx_fifo_enable = 1'b0;
        tx_fifo_enable = 1'b0;
        w_tx_word      = '0;
        w_msg_inc      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_start) begin
                    case (t_qa_hc_exer_mode'(cfg_mode))
                        MODE_CHECK:    w_next_state = ST_CHECK;
                        MODE_GENERATE: w_next_state = ST_GENERATE;
                        MODE_ECHO:     w_next_state = ST_ECHO;
                        default:       w_next_state = ST_IDLE;
                    endcase
                end
            end
            ST_CHECK: begin
                rx_fifo_enable = rx_fifo_rdy;
                w_msg_inc      = rx_fifo_rdy;
                if (rx_fifo_rdy && w_rx_word[MSG_LAST_BIT]) begin
                    w_next_state = ST_REPORT;
                end
            end
            ST_REPORT: begin
                tx_fifo_enable = tx_fifo_rdy;
                w_tx_word[RPT_ERR_MSB:RPT_ERR_LSB] = w_err_rpt;
                w_tx_word[RPT_MSG_MSB:RPT_MSG_LSB] = r_msg_count[15:0];
                if (tx_fifo_rdy) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_GENERATE: begin
                tx_fifo_enable = tx_fifo_rdy;
                w_msg_inc      = tx_fifo_rdy;
                w_tx_word      = qa_hc_msg(r_cnt, r_cnt == 31'd1);
                if (tx_fifo_rdy && (r_cnt == 31'd1)) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ECHO: begin
                rx_fifo_enable = rx_fifo_rdy && tx_fifo_rdy;
                tx_fifo_enable = rx_fifo_rdy && tx_fifo_rdy;
                w_msg_inc      = rx_fifo_rdy && tx_fifo_rdy;
                w_tx_word      = w_rx_word;
                if (rx_fifo_rdy && tx_fifo_rdy && w_rx_word[MSG_LAST_BIT]) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_err_count <= '0;
            r_msg_count <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (r_state != ST_IDLE) && (w_next_state == ST_IDLE);
            if (w_start) begin
                r_err_count <= '0;
                r_msg_count <= '0;
                r_cnt       <= (cfg_count == 31'd0) ? 31'd1 : cfg_count;
            end else begin
                if (w_msg_inc) begin
                    r_msg_count <= r_msg_count + 32'd1;
                end
                if (w_err_inc && (r_err_count != {ERR_WIDTH{1'b1}})) begin
                    r_err_count <= r_err_count + 1'b1;
                end
                if (w_gen_push) begin
                    r_cnt <= r_cnt - 31'd1;
                end
            end
        end
    end

    qa_drv_hc_seq_checker u_seq_checker (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_start),
        .i_msg_valid (w_chk_valid),
        .i_data      (w_rx_word),
        .o_err_inc   (w_err_inc)
    );

    assign tx_fifo_data = {{(DATA_WIDTH-32){1'b0}}, w_tx_word};
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign err_count    = r_err_count;
    assign msg_count    = r_msg_count;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_qa_drv_hc_client_exerciser.sv
// Bench for the host-channel client exerciser: host-side FIFO models, a tx scoreboard,
// and directed CHECK / GENERATE / ECHO / reset scenarios.
module tb_qa_drv_hc_client_exerciser;

    localparam int DW = 512;
    localparam int EW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_start = 1'b0;
    logic [1:0]    cfg_mode = 2'd0;
    logic [30:0]   cfg_count = 31'd0;
    logic [DW-1:0] rx_fifo_data = '0;
    logic          rx_fifo_rdy = 1'b0;
    logic          rx_fifo_enable;
    logic [DW-1:0] tx_fifo_data;
    logic          tx_fifo_rdy = 1'b0;
    logic          tx_fifo_enable;
    logic          busy;
    logic          done;
    logic [EW-1:0] err_count;
    logic [31:0]   msg_count;
    logic [2:0]    dbg_state;

    logic [31:0] exp_q[$];
    logic [31:0] rx_q[$];

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int push_cnt = 0;
    int tx_low_cnt = 0;
    bit tx_toggle = 1'b0;

    always #5 clk = ~clk;

    qa_drv_hc_client_exerciser #(.DATA_WIDTH(DW), .ERR_WIDTH(EW)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_start      (cfg_start),
        .cfg_mode       (cfg_mode),
        .cfg_count      (cfg_count),
        .rx_fifo_data   (rx_fifo_data),
        .rx_fifo_rdy    (rx_fifo_rdy),
        .rx_fifo_enable (rx_fifo_enable),
        .tx_fifo_data   (tx_fifo_data),
        .tx_fifo_rdy    (tx_fifo_rdy),
        .tx_fifo_enable (tx_fifo_enable),
        .busy           (busy),
        .done           (done),
        .err_count      (err_count),
        .msg_count      (msg_count),
        .dbg_state      (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int count, input bit last);
        logic [30:0] c;
        c = 31'(count);
        return {c, last};
    endfunction

    // One clock: sample at negedge, then update host-side inputs #1 after posedge.
    task automatic cycle();
        logic took;
        @(negedge clk);
        check("rx_en_rdy", 64'(rx_fifo_enable & ~rx_fifo_rdy), 64'd0);
        check("tx_en_rdy", 64'(tx_fifo_enable & ~tx_fifo_rdy), 64'd0);
        if (tx_fifo_enable) begin
            push_cnt++;
            check("tx_hi_zero", 64'(|tx_fifo_data[DW-1:32]), 64'd0);
            if (exp_q.size() == 0) begin
                check("tx_extra_push", {32'd0, tx_fifo_data[31:0]}, 64'hFFFF_FFFF_0000_0000);
            end else begin
                check("tx_word", {32'd0, tx_fifo_data[31:0]}, {32'd0, exp_q.pop_front()});
            end
        end
        if (done) done_cnt++;
        took = rx_fifo_enable;
        @(posedge clk);
        #1;
        if (took && rx_q.size() != 0) void'(rx_q.pop_front());
        cfg_start = 1'b0;
        if (rx_q.size() != 0) begin
            rx_fifo_rdy  = 1'b1;
            rx_fifo_data = DW'(rx_q[0]);
        end else begin
            rx_fifo_rdy  = 1'b0;
            rx_fifo_data = '0;
        end
        if (tx_low_cnt > 0) begin
            tx_fifo_rdy = 1'b0;
            tx_low_cnt--;
        end else if (tx_toggle) begin
            tx_fifo_rdy = ~tx_fifo_rdy;
        end else begin
            tx_fifo_rdy = 1'b1;
        end
    endtask

    task automatic pulse_start(input logic [1:0] mode, input logic [30:0] count);
        cfg_start = 1'b1;
        cfg_mode  = mode;
        cfg_count = count;
        cycle();
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
        cycle();
        cycle();
        check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_exp_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int d0;

        // Reset state
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        check("rst_msg", 64'(msg_count), 64'd0);
        check("rst_tx_data", 64'(tx_fifo_data[63:0]), 64'd0);
        check("rst_en", 64'({rx_fifo_enable, tx_fifo_enable}), 64'd0);

        // CHECK, clean stream 5..1
        tx_toggle = 1'b0;
        for (int i = 5; i >= 1; i--) rx_q.push_back(mk(i, i == 1));
        exp_q.push_back(32'h0000_0005);
        pulse_start(2'd1, 31'd0);
        run_until_done("chk_ok", 100);
        check("chk_ok_msg", 64'(msg_count), 64'd5);
        check("chk_ok_err", 64'(err_count), 64'd0);
        check("chk_ok_rx_drained", 64'(rx_q.size()), 64'd0);

        // CHECK, gap 5,4,2,1: one error, resync on 1
        rx_q.push_back(mk(5, 0));
        rx_q.push_back(mk(4, 0));
        rx_q.push_back(mk(2, 0));
        rx_q.push_back(mk(1, 1));
        exp_q.push_back(32'h0001_0004);
        pulse_start(2'd1, 31'd0);
        run_until_done("chk_gap", 100);
        check("chk_gap_msg", 64'(msg_count), 64'd4);
        check("chk_gap_err", 64'(err_count), 64'd1);

        // CHECK, single message with bad last flag
        rx_q.push_back(mk(3, 1));
        exp_q.push_back(32'h0001_0001);
        pulse_start(2'd1, 31'd0);
        run_until_done("chk_last", 100);
        check("chk_last_err", 64'(err_count), 64'd1);

        // CHECK, final message carries both errors: counted once
        rx_q.push_back(mk(5, 0));
        rx_q.push_back(mk(2, 1));
        exp_q.push_back(32'h0001_0002);
        pulse_start(2'd1, 31'd0);
        run_until_done("chk_both", 100);
        check("chk_both_err", 64'(err_count), 64'd1);
        check("chk_both_msg", 64'(msg_count), 64'd2);

        // GENERATE 3 with tx_fifo_rdy toggling
        tx_fifo_rdy = 1'b1;
        tx_toggle = 1'b1;
        exp_q.push_back(32'h6);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h3);
        p0 = push_cnt;
        pulse_start(2'd2, 31'd3);
        run_until_done("gen3", 100);
        check("gen3_pushes", 64'(push_cnt - p0), 64'd3);
        check("gen3_msg", 64'(msg_count), 64'd3);
        tx_toggle = 1'b0;

        // GENERATE with count 0 behaves as 1
        exp_q.push_back(32'h3);
        p0 = push_cnt;
        pulse_start(2'd2, 31'd0);
        run_until_done("gen0", 100);
        repeat (3) cycle();
        check("gen0_pushes", 64'(push_cnt - p0), 64'd1);
        check("gen0_msg", 64'(msg_count), 64'd1);

        // ECHO with tx held off for 4 cycles
        rx_q.push_back(32'h10);
        rx_q.push_back(32'h21);
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h21);
        tx_fifo_rdy = 1'b0;
        tx_low_cnt = 4;
        pulse_start(2'd3, 31'd0);
        repeat (4) cycle();
        check("echo_hold_rx", 64'(rx_q.size()), 64'd2);
        check("echo_hold_msg", 64'(msg_count), 64'd0);
        run_until_done("echo", 100);
        check("echo_msg", 64'(msg_count), 64'd2);
        check("echo_rx_drained", 64'(rx_q.size()), 64'd0);

        // NOP start is ignored
        pulse_start(2'd0, 31'd4);
        check("nop_busy", 64'(busy), 64'd0);
        check("nop_msg_kept", 64'(msg_count), 64'd2);

        // Restart while busy ignored; reset mid-GENERATE at cnt=7
        tx_fifo_rdy = 1'b1;
        exp_q.push_back(mk(10, 0));
        exp_q.push_back(mk(9, 0));
        exp_q.push_back(mk(8, 0));
        p0 = push_cnt;
        d0 = done_cnt;
        pulse_start(2'd2, 31'd10);
        cycle();
        pulse_start(2'd1, 31'd1);
        cycle();
        check("gen_mid_pushes", 64'(push_cnt - p0), 64'd3);
        check("gen_mid_msg", 64'(msg_count), 64'd3);
        check("gen_mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tx_fifo_rdy = 1'b0;
        tx_low_cnt = 2;
        cycle();
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_msg", 64'(msg_count), 64'd0);
        check("abort_err", 64'(err_count), 64'd0);
        check("abort_tx_data", 64'(tx_fifo_data[63:0]), 64'd0);
        check("abort_state", 64'(dbg_state), 64'd0);
        rx_q.push_back(mk(1, 1));
        repeat (3) cycle();
        check("abort_idle_en", 64'({rx_fifo_enable, tx_fifo_enable}), 64'd0);
        check("abort_rx_kept", 64'(rx_q.size()), 64'd1);
        check("abort_no_push", 64'(push_cnt - p0), 64'd3);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_exp_drained", 64'(exp_q.size()), 64'd0);
        rx_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
